// File: rtl/iecdrv_head_ctl_pkg.sv
// Shared constants and types for the multi-drive head-position controller.
package iecdrv_head_ctl_pkg;

  // Half-track position width: 0..127 covers every legal head position.
  localparam int HTRK_W = 7;
  typedef logic [HTRK_W-1:0] htrk_t;

  // Stepper phase difference (new - old, mod 4) meaning one half-track in / out.
  localparam logic [1:0] MOVE_IN  = 2'd1;
  localparam logic [1:0] MOVE_OUT = 2'd3;

  // One track write-back request as presented to the SD track loader.
  typedef struct packed {
    logic [2:0] drv;
    htrk_t      htrack;
  } save_req_t;

  // Drive-index width, never narrower than one bit.
  function automatic int drv_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iecdrv_head_ctl_if.sv
// Track-save request port between the head controller and the SD track loader.
//
// Handshake: save_valid, save_drv and save_htrack are driven by the master and
// stay stable while save_valid is high and save_ready is low; a transfer
// happens on every clock edge where save_valid & save_ready are both high.
// The master may drop save_valid without a transfer only when the request is
// withdrawn because the drive received a new image.
interface iecdrv_head_ctl_if
  import iecdrv_head_ctl_pkg::*;
#(
  parameter int NUM_DRV = 4
);
  localparam int DRV_W = drv_w(NUM_DRV);

  logic             save_valid;
  logic             save_ready;
  logic [DRV_W-1:0] save_drv;
  htrk_t            save_htrack;

  modport master (output save_valid, output save_drv, output save_htrack, input save_ready);
  modport slave  (input save_valid, input save_drv, input save_htrack, output save_ready);
endinterface

// File: rtl/iecdrv_head_chan.sv
// One drive channel: stepper decode with half-track clamp, dirty tracking,
// single save slot with sticky overflow, and disk-change timeout emulation.
// Optional build macro IECDRV_IDLE_FLUSH_EN: a dirty track is also queued for
// write-back when drive activity stops.
module iecdrv_head_chan
  import iecdrv_head_ctl_pkg::*;
#(
  parameter int HTRK_MAX = 84,
  parameter int HTRK_RST = 36,
  parameter int CHG_W    = 25,
  parameter int WPS_BIT  = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] stp,
  input  logic       mtr,
  input  logic       act,
  input  logic       we,
  input  logic       img_mounted,
  input  logic       img_readonly,
  input  logic       img_present,
  input  logic       clr,
  output htrk_t      htrack,
  output logic       tr00_sense_n,
  output logic       wps_n,
  output logic       disk_present,
  output logic       pending,
  output htrk_t      slot_htrack,
  output logic       save_ovf,
  output logic       mount_edge
);

  logic [1:0]       stp_q;
  logic             mnt_q;
  logic             dirty;
  logic             ro_q;
  logic             pres_q;
  logic [CHG_W-1:0] timeout;
  logic [1:0]       move;
  logic             step_evt;
  logic             flush_evt;
  logic             save_evt;

  assign move       = stp - stp_q;
  assign step_evt   = mtr & move[0];
  assign mount_edge = img_mounted & ~mnt_q;

`ifdef IECDRV_IDLE_FLUSH_EN
  // Activity stopped with unsaved data: write the current track back.
  assign flush_evt = dirty & ~act;
`else
  logic unused_act;
  assign unused_act = act;
  assign flush_evt  = 1'b0;
`endif

  // Any odd phase move counts as a step for saving, even when clamped.
  assign save_evt = dirty & (step_evt | flush_evt);

  assign tr00_sense_n = (htrack != '0);
  assign wps_n        = ~ro_q ^ timeout[WPS_BIT];
  assign disk_present = pres_q & (timeout == '0);

  // Previous stepper phase and mount level for move / edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      stp_q <= stp;
      mnt_q <= 1'b0;
    end else begin
      stp_q <= stp;
      mnt_q <= img_mounted;
    end
  end

  // Head position: one half-track per accepted step, clamped to 0..HTRK_MAX.
  always_ff @(posedge clk) begin
    if (reset) begin
      htrack <= htrk_t'(HTRK_RST);
    end else if (mtr && move == MOVE_IN && htrack < htrk_t'(HTRK_MAX)) begin
      htrack <= htrack + 1'b1;
    end else if (mtr && move == MOVE_OUT && htrack != '0) begin
      htrack <= htrack - 1'b1;
    end
  end

  // Dirty flag and save slot; the slot keeps the track the head is leaving.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty       <= 1'b0;
      pending     <= 1'b0;
      slot_htrack <= '0;
      save_ovf    <= 1'b0;
    end else if (mount_edge) begin
      dirty    <= 1'b0;
      pending  <= 1'b0;
      save_ovf <= 1'b0;
    end else begin
      if (clr) pending <= 1'b0;
      if (save_evt) begin
        if (pending) begin
          save_ovf <= 1'b1;
        end else begin
          pending     <= 1'b1;
          slot_htrack <= htrack;
        end
      end
      // A write in the step cycle belongs to the new track, so it wins.
      if (we) dirty <= 1'b1;
      else if (save_evt) dirty <= 1'b0;
    end
  end

  // Disk-change emulation: timeout reloads on mount, counts down on ce.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout <= '0;
      ro_q    <= 1'b0;
      pres_q  <= 1'b0;
    end else if (mount_edge) begin
      timeout <= '1;
      ro_q    <= img_readonly;
      pres_q  <= img_present;
    end else if (ce && timeout != '0) begin
      timeout <= timeout - CHG_W'(1);
    end
  end

endmodule

// File: rtl/iecdrv_head_ctl.sv
// Multi-drive head controller top: NUM_DRV drive channels plus a round-robin
// arbiter feeding one registered track-save request port.
// Optional build macro IECDRV_IDLE_FLUSH_EN (see iecdrv_head_chan).
module iecdrv_head_ctl
  import iecdrv_head_ctl_pkg::*;
#(
  parameter int NUM_DRV  = 4,
  parameter int HTRK_MAX = 84,
  parameter int HTRK_RST = 36,
  parameter int CHG_W    = 25,
  parameter int WPS_BIT  = 23
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [2*NUM_DRV-1:0]      stp,
  input  logic [NUM_DRV-1:0]        mtr,
  input  logic [NUM_DRV-1:0]        act,
  input  logic [NUM_DRV-1:0]        we,
  input  logic [NUM_DRV-1:0]        img_mounted,
  input  logic [NUM_DRV-1:0]        img_readonly,
  input  logic [NUM_DRV-1:0]        img_present,
  output logic [HTRK_W*NUM_DRV-1:0] htrack,
  output logic [NUM_DRV-1:0]        tr00_sense_n,
  output logic [NUM_DRV-1:0]        wps_n,
  output logic [NUM_DRV-1:0]        disk_present,
  iecdrv_head_ctl_if.master         save_if,
  output logic [NUM_DRV-1:0]        save_ovf
);

  localparam int DRV_W = drv_w(NUM_DRV);
  localparam int IDX_W = DRV_W + 1;

  logic [NUM_DRV-1:0] pending;
  logic [NUM_DRV-1:0] mount_edge;
  logic [NUM_DRV-1:0] clr;
  logic [NUM_DRV-1:0] avail;
  htrk_t              slot_ht [NUM_DRV];

  save_req_t          port_q;
  logic               port_valid;
  logic [DRV_W-1:0]   port_drv;
  logic [DRV_W-1:0]   last_drv;
  logic [DRV_W-1:0]   pick_drv;
  logic               pick_found;
  logic [IDX_W-1:0]   idx;
  logic               unused_drv_hi;

  for (genvar d = 0; d < NUM_DRV; d++) begin : g_chan
    iecdrv_head_chan #(
      .HTRK_MAX (HTRK_MAX),
      .HTRK_RST (HTRK_RST),
      .CHG_W    (CHG_W),
      .WPS_BIT  (WPS_BIT)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .ce           (ce),
      .stp          (stp[2*d +: 2]),
      .mtr          (mtr[d]),
      .act          (act[d]),
      .we           (we[d]),
      .img_mounted  (img_mounted[d]),
      .img_readonly (img_readonly[d]),
      .img_present  (img_present[d]),
      .clr          (clr[d]),
      .htrack       (htrack[d*HTRK_W +: HTRK_W]),
      .tr00_sense_n (tr00_sense_n[d]),
      .wps_n        (wps_n[d]),
      .disk_present (disk_present[d]),
      .pending      (pending[d]),
      .slot_htrack  (slot_ht[d]),
      .save_ovf     (save_ovf[d]),
      .mount_edge   (mount_edge[d])
    );
  end

  assign port_drv      = port_q.drv[DRV_W-1:0];
  assign unused_drv_hi = ^port_q.drv;

  // A slot being emptied by a mount this cycle must not be granted.
  assign avail = pending & ~mount_edge;

  // Completed transfer frees the granted drive's slot.
  assign clr = (port_valid & save_if.save_ready) ? (NUM_DRV'(1) << port_drv) : '0;

  assign save_if.save_valid  = port_valid;
  assign save_if.save_drv    = port_drv;
  assign save_if.save_htrack = port_q.htrack;

  // Round-robin pick: first available slot after the last granted drive.
  always_comb begin
    pick_found = 1'b0;
    pick_drv   = '0;
    idx        = '0;
    for (int i = 1; i <= NUM_DRV; i++) begin
      idx = {1'b0, last_drv} + IDX_W'(i);
      if (idx >= IDX_W'(NUM_DRV)) idx = idx - IDX_W'(NUM_DRV);
      if (!pick_found && avail[idx[DRV_W-1:0]]) begin
        pick_found = 1'b1;
        pick_drv   = idx[DRV_W-1:0];
      end
    end
  end

  // Save port register: hold until accepted or withdrawn, then regrant.
  always_ff @(posedge clk) begin
    if (reset) begin
      port_valid <= 1'b0;
      port_q     <= '0;
      last_drv   <= DRV_W'(NUM_DRV - 1);
    end else if (port_valid) begin
      if (save_if.save_ready || mount_edge[port_drv]) port_valid <= 1'b0;
    end else if (pick_found) begin
      port_valid    <= 1'b1;
      port_q.drv    <= 3'(pick_drv);
      port_q.htrack <= slot_ht[pick_drv];
      last_drv      <= pick_drv;
    end
  end

endmodule

// File: tb/tb_iecdrv_head_ctl.sv
// Bench for iecdrv_head_ctl: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural model.
module tb_iecdrv_head_ctl;

  localparam int N   = 4;
  localparam int HW  = 7;
  localparam int HM  = 84;
  localparam int HR  = 36;
  localparam int CW  = 4;
  localparam int WB  = 2;
  localparam int TOM = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ce = 1'b0;
  logic [2*N-1:0]  stp = '0;
  logic [N-1:0]    mtr = '0;
  logic [N-1:0]    act = '0;
  logic [N-1:0]    we = '0;
  logic [N-1:0]    img_mounted = '0;
  logic [N-1:0]    img_readonly = '0;
  logic [N-1:0]    img_present = '0;
  logic            save_ready = 1'b0;
  wire [HW*N-1:0]  htrack;
  wire [N-1:0]     tr00_sense_n;
  wire [N-1:0]     wps_n;
  wire [N-1:0]     disk_present;
  wire [N-1:0]     save_ovf;

  iecdrv_head_ctl_if #(.NUM_DRV(N)) sif ();
  assign sif.save_ready = save_ready;

  iecdrv_head_ctl #(
    .NUM_DRV  (N),
    .HTRK_MAX (HM),
    .HTRK_RST (HR),
    .CHG_W    (CW),
    .WPS_BIT  (WB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ce           (ce),
    .stp          (stp),
    .mtr          (mtr),
    .act          (act),
    .we           (we),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_present  (img_present),
    .htrack       (htrack),
    .tr00_sense_n (tr00_sense_n),
    .wps_n        (wps_n),
    .disk_present (disk_present),
    .save_if      (sif),
    .save_ovf     (save_ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int d, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0d expected %0d at %0t", nm, d, got, exp, $time);
    end
  endtask

  function automatic int dut_ht(input int d);
    return int'(htrack[d*HW +: HW]);
  endfunction

  // ---------------- behavioural model ----------------
  int m_ht [N];
  int m_stpq [N];
  int m_slot [N];
  int m_to [N];
  bit m_dirty [N];
  bit m_pend [N];
  bit m_ovf [N];
  bit m_ro [N];
  bit m_pres [N];
  bit m_mntq [N];
  bit m_valid;
  int m_drv;
  int m_pht;
  int m_last;

  task automatic model_step();
    bit mnt [N];
    bit nv;
    int ndrv, nht, nlast;
    if (reset) begin
      for (int d = 0; d < N; d++) begin
        m_ht[d] = HR; m_stpq[d] = int'(stp[2*d +: 2]);
        m_dirty[d] = 0; m_pend[d] = 0; m_slot[d] = 0; m_ovf[d] = 0;
        m_to[d] = 0; m_ro[d] = 0; m_pres[d] = 0; m_mntq[d] = 0;
      end
      m_valid = 0; m_drv = 0; m_pht = 0; m_last = N - 1;
      return;
    end
    for (int d = 0; d < N; d++) mnt[d] = img_mounted[d] && !m_mntq[d];
    // port: hold until accepted / withdrawn, else grant next pending after last
    nv = m_valid; ndrv = m_drv; nht = m_pht; nlast = m_last;
    if (m_valid) begin
      if (save_ready || mnt[m_drv]) nv = 0;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!nv && m_pend[c] && !mnt[c]) begin
          nv = 1; ndrv = c; nht = m_slot[c]; nlast = c;
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      int mv;
      bit stepped, ev, flush, done;
      mv = (int'(stp[2*d +: 2]) - m_stpq[d] + 4) % 4;
      stepped = mtr[d] && (mv % 2 == 1);
`ifdef IECDRV_IDLE_FLUSH_EN
      flush = !act[d];
`else
      flush = 0;
`endif
      ev = m_dirty[d] && (stepped || flush);
      done = m_valid && save_ready && (m_drv == d);
      if (mnt[d]) begin
        m_dirty[d] = 0; m_pend[d] = 0; m_ovf[d] = 0;
        m_to[d] = TOM; m_ro[d] = img_readonly[d]; m_pres[d] = img_present[d];
      end else begin
        if (ev && m_pend[d]) m_ovf[d] = 1;
        else if (ev) begin m_pend[d] = 1; m_slot[d] = m_ht[d]; end
        if (done) m_pend[d] = 0;
        if (we[d]) m_dirty[d] = 1;
        else if (ev) m_dirty[d] = 0;
        if (ce && m_to[d] > 0) m_to[d] = m_to[d] - 1;
      end
      if (mtr[d] && mv == 1 && m_ht[d] < HM) m_ht[d] = m_ht[d] + 1;
      else if (mtr[d] && mv == 3 && m_ht[d] > 0) m_ht[d] = m_ht[d] - 1;
      m_stpq[d] = int'(stp[2*d +: 2]);
      m_mntq[d] = img_mounted[d];
    end
    m_valid = nv; m_drv = ndrv; m_pht = nht; m_last = nlast;
  endtask

  task automatic compare_all();
    for (int d = 0; d < N; d++) begin
      chk("htrack", d, dut_ht(d), m_ht[d]);
      chk("tr00_sense_n", d, int'(tr00_sense_n[d]), (m_ht[d] != 0) ? 1 : 0);
      chk("wps_n", d, int'(wps_n[d]), int'(!m_ro[d]) ^ ((m_to[d] >> WB) & 1));
      chk("disk_present", d, int'(disk_present[d]), (m_pres[d] && m_to[d] == 0) ? 1 : 0);
      chk("save_ovf", d, int'(save_ovf[d]), int'(m_ovf[d]));
    end
    chk("save_valid", -1, int'(sif.save_valid), int'(m_valid));
    if (m_valid) begin
      chk("save_drv", -1, int'(sif.save_drv), m_drv);
      chk("save_htrack", -1, int'(sif.save_htrack), m_pht);
    end
  endtask

  // Model advances on the edge with the same inputs the DUT sees; compare after.
  always @(posedge clk) begin
    model_step();
    #1;
    compare_all();
  end

  // ---------------- driver tasks ----------------
  int g_drv[$];
  int g_ht[$];

  task automatic step_mask(input logic [N-1:0] m, input logic [1:0] dir);
    for (int d = 0; d < N; d++)
      if (m[d]) stp[2*d +: 2] = stp[2*d +: 2] + dir;
    @(negedge clk);
  endtask

  task automatic we_pulse(input logic [N-1:0] m);
    we = m;
    @(negedge clk);
    we = '0;
  endtask

  task automatic collect(input int want);
    g_drv.delete();
    g_ht.delete();
    save_ready = 1'b1;
    for (int c = 0; c < 30 && g_drv.size() < want; c++) begin
      if (sif.save_valid) begin
        g_drv.push_back(int'(sif.save_drv));
        g_ht.push_back(int'(sif.save_htrack));
      end
      @(negedge clk);
    end
    save_ready = 1'b0;
    chk("grant_count", -1, g_drv.size(), want);
  endtask

  function automatic int q_at(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // reset state
    for (int d = 0; d < N; d++) chk("rst_htrack", d, dut_ht(d), 36);
    chk("rst_valid", -1, int'(sif.save_valid), 0);
    chk("rst_ovf", -1, int'(save_ovf), 0);
    chk("rst_present", -1, int'(disk_present), 0);
    chk("model_rst_ht", 0, m_ht[0], 36);

    // single steps on drive 0
    mtr[0] = 1'b1;
    step_mask(4'b0001, 2'd1);
    chk("step_in", 0, dut_ht(0), 37);
    chk("model_step_in", 0, m_ht[0], 37);
    step_mask(4'b0001, 2'd2);
    chk("move2_ignored", 0, dut_ht(0), 37);
    mtr[0] = 1'b0;
    step_mask(4'b0001, 2'd1);
    chk("mtr_off", 0, dut_ht(0), 37);
    mtr[0] = 1'b1;

    // clamp at both ends
    repeat (85) step_mask(4'b0001, 2'd3);
    chk("clamp_low", 0, dut_ht(0), 0);
    chk("tr00", 0, int'(tr00_sense_n[0]), 0);
    step_mask(4'b0001, 2'd3);
    chk("no_underflow", 0, dut_ht(0), 0);
    repeat (90) step_mask(4'b0001, 2'd1);
    chk("clamp_high", 0, dut_ht(0), 84);
    chk("model_clamp_high", 0, m_ht[0], 84);

    // burst on drives 0,2,3 from reset pointer: grants 0,2,3
    mtr = '1;
    we_pulse(4'b1101);
    step_mask(4'b1101, 2'd3);
    collect(3);
    chk("burst1_drv0", 0, q_at(g_drv, 0), 0);
    chk("burst1_drv1", 1, q_at(g_drv, 1), 2);
    chk("burst1_drv2", 2, q_at(g_drv, 2), 3);
    chk("burst1_ht0", 0, q_at(g_ht, 0), 84);
    chk("burst1_ht1", 1, q_at(g_ht, 1), 36);
    chk("burst1_ht2", 2, q_at(g_ht, 2), 36);

    // drive 1 request held stable under backpressure
    we_pulse(4'b0010);
    step_mask(4'b0010, 2'd1);
    @(negedge clk);
    for (int c = 0; c < 11; c++) begin
      chk("hold_valid", c, int'(sif.save_valid), 1);
      chk("hold_drv", c, int'(sif.save_drv), 1);
      chk("hold_htrack", c, int'(sif.save_htrack), 36);
      @(negedge clk);
    end
    save_ready = 1'b1;
    @(negedge clk);
    save_ready = 1'b0;
    chk("hold_released", -1, int'(sif.save_valid), 0);

    // burst on 0,1,2 after last grant 1: round robin gives 2,0,1
    we_pulse(4'b0111);
    step_mask(4'b0111, 2'd3);
    collect(3);
    chk("burst2_drv0", 0, q_at(g_drv, 0), 2);
    chk("burst2_drv1", 1, q_at(g_drv, 1), 0);
    chk("burst2_drv2", 2, q_at(g_drv, 2), 1);
    chk("burst2_ht0", 0, q_at(g_ht, 0), 35);
    chk("burst2_ht1", 1, q_at(g_ht, 1), 83);
    chk("burst2_ht2", 2, q_at(g_ht, 2), 37);

    // overflow on drive 2 while its slot is full
    we_pulse(4'b0100);
    step_mask(4'b0100, 2'd1);
    @(negedge clk);
    chk("ovf_first_valid", 2, int'(sif.save_valid), 1);
    chk("ovf_first_ht", 2, int'(sif.save_htrack), 34);
    we_pulse(4'b0100);
    step_mask(4'b0100, 2'd1);
    chk("ovf_set", 2, int'(save_ovf[2]), 1);
    chk("ovf_slot_kept", 2, int'(sif.save_htrack), 34);
    chk("ovf_head", 2, dut_ht(2), 36);

    // mount drive 2: clears ovf/slot, withdraws request, change timing
    img_readonly[2] = 1'b1;
    img_present[2] = 1'b1;
    img_mounted[2] = 1'b1;
    @(negedge clk);
    chk("mnt_ovf_clr", 2, int'(save_ovf[2]), 0);
    chk("mnt_withdraw", 2, int'(sif.save_valid), 0);
    chk("mnt_present0", 2, int'(disk_present[2]), 0);
    chk("mnt_wps", 2, int'(wps_n[2]), 1);
    ce = 1'b1;
    repeat (14) @(negedge clk);
    chk("chg_14_present", 2, int'(disk_present[2]), 0);
    chk("chg_14_wps", 2, int'(wps_n[2]), 0);
    @(negedge clk);
    chk("chg_15_present", 2, int'(disk_present[2]), 1);
    chk("no_regrant", 2, int'(sif.save_valid), 0);
    ce = 1'b0;
    img_mounted[2] = 1'b0;

    // idle flush on drive 3
    act[3] = 1'b1;
    we_pulse(4'b1000);
    act[3] = 1'b0;
    repeat (2) @(negedge clk);
`ifdef IECDRV_IDLE_FLUSH_EN
    chk("flush_valid", 3, int'(sif.save_valid), 1);
    chk("flush_drv", 3, int'(sif.save_drv), 3);
    chk("flush_ht", 3, int'(sif.save_htrack), 35);
`else
    chk("no_flush", 3, int'(sif.save_valid), 0);
`endif
    save_ready = 1'b1;
    @(negedge clk);
    save_ready = 1'b0;

    // randomized traffic, checked by the per-cycle compare
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 3) == 0) stp[2*d +: 2] = 2'($urandom_range(0, 3));
        we[d] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 7) == 0) act[d] = ~act[d];
        if ($urandom_range(0, 59) == 0) img_mounted[d] = ~img_mounted[d];
        img_readonly[d] = 1'($urandom_range(0, 1));
        img_present[d] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) mtr = N'($urandom);
      ce = 1'($urandom_range(0, 1));
      save_ready = ($urandom_range(0, 2) != 0);
      reset = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    we = '0;
    save_ready = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
